kiwi_bist_ctrl: RTL and testbench

Synthesizable built-in self-test controller for the Kiwi SDR receiver datapath. It generates a selectable ADC stimulus pattern, pulses the DSP chain reset, then watches the FIFO fill counts of N receiver/waterfall channels against a threshold and a timeout. It sits between the ADC input mux and the status register bank, so the PS can run a receiver self-test on hardware without a simulator.

---
 rtl/kiwi_bist_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_kiwi_bist_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/kiwi_bist_ctrl.sv
// Receiver self-test controller: drives a stimulus pattern into the ADC path, pulses the
// DSP reset, then grades each channel's FIFO fill count against a threshold within a timeout.
module kiwi_bist_ctrl #(
    parameter int ADC_WIDTH   = 16,
    parameter int CHANNELS    = 3,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMER_WIDTH = 32,
    parameter int RST_CYCLES  = 16,
    parameter int SQ_HALF     = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [1:0]                    cfg_mode,
    input  logic [ADC_WIDTH-1:0]          cfg_step,
    input  logic [TIMER_WIDTH-1:0]        cfg_timeout,
    input  logic [CNT_WIDTH-1:0]          cfg_threshold,
    input  logic                          start,
    input  logic [CHANNELS*CNT_WIDTH-1:0] fifo_count,
    output logic [ADC_WIDTH-1:0]          adc_dat,
    output logic                          adc_valid,
    output logic                          dsp_rst,
    output logic                          sts_busy,
    output logic                          sts_done,
    output logic [CHANNELS-1:0]           sts_pass,
    output logic                          sts_fail_any,
    output logic [2:0]                    dbg_state
);

    localparam int SQ_W  = $clog2(2 * SQ_HALF);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_mode;
    logic [ADC_WIDTH-1:0]   r_step;
    logic [TIMER_WIDTH-1:0] r_timeout;
    logic [CNT_WIDTH-1:0]   r_thr;
    logic [CHANNELS-1:0]    r_hit;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [RST_W-1:0]       r_rst_cnt;
    logic [31:0]            r_lfsr;
    logic [SQ_W-1:0]        r_sq_cnt;
    logic [ADC_WIDTH-1:0]   r_dat;
    logic                   r_valid;
    logic                   r_dsp_rst;
    logic                   r_busy;
    logic                   r_done;
    logic [CHANNELS-1:0]    r_pass;
    logic                   r_fail_any;

    logic [CHANNELS-1:0]    w_cmp;
    logic [CHANNELS-1:0]    w_final;
    logic                   w_hit_all;
    logic                   w_tmo;
    logic [31:0]            w_lfsr_nxt;
    logic [SQ_W-1:0]        w_sq_nxt;
    logic [ADC_WIDTH-1:0]   w_first;
    logic [ADC_WIDTH-1:0]   w_next;

    always_comb begin
        w_cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cmp[i] = fifo_count[i*CNT_WIDTH +: CNT_WIDTH] >= r_thr;
        end
    end

    // Exit decision uses this cycle's compare so a hit in RUN cycle k lands in CHECK at k+1.
    assign w_final    = r_hit | w_cmp;
    assign w_hit_all  = &w_final;
    assign w_tmo      = (r_timer == r_timeout - TIMER_WIDTH'(1));
    assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'hA300_0000 : 32'h0);
    assign w_sq_nxt   = (r_sq_cnt == SQ_W'(2 * SQ_HALF - 1)) ? '0 : r_sq_cnt + SQ_W'(1);

    always_comb begin
        w_first = '0;
        w_next  = '0;
        case (r_mode)
            2'd0: begin
                w_first = '0;
                w_next  = r_dat + r_step;
            end
            2'd1: begin
                w_first = ADC_WIDTH'(1);
                w_next  = w_lfsr_nxt[ADC_WIDTH-1:0];
            end
            2'd2: begin
                w_first = r_step;
                w_next  = r_step;
            end
            default: begin
                w_first = r_step;
                w_next  = (w_sq_nxt < SQ_W'(SQ_HALF)) ? r_step : '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_step     <= '0;
            r_timeout  <= TIMER_WIDTH'(1);
            r_thr      <= '0;
            r_hit      <= '0;
            r_timer    <= '0;
            r_rst_cnt  <= '0;
            r_lfsr     <= 32'h1;
            r_sq_cnt   <= '0;
            r_dat      <= '0;
            r_valid    <= 1'b0;
            r_dsp_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= '0;
            r_fail_any <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mode     <= cfg_mode;
                        r_step     <= cfg_step;
                        r_timeout  <= (cfg_timeout == '0) ? TIMER_WIDTH'(1) : cfg_timeout;
                        r_thr      <= cfg_threshold;
                        r_hit      <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= '0;
                        r_fail_any <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dsp_rst  <= 1'b1;
                        r_rst_cnt  <= '0;
                        r_state    <= S_RST;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        r_dsp_rst <= 1'b0;
                        r_valid   <= 1'b1;
                        r_timer   <= '0;
                        r_lfsr    <= 32'h1;
                        r_sq_cnt  <= '0;
                        r_dat     <= w_first;
                        r_state   <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                S_RUN: begin
                    r_hit <= w_final;
                    if (w_hit_all || w_tmo) begin
                        r_valid <= 1'b0;
                        r_dat   <= '0;
                        r_state <= S_CHECK;
                    end else begin
                        r_timer  <= r_timer + TIMER_WIDTH'(1);
                        r_lfsr   <= w_lfsr_nxt;
                        r_sq_cnt <= w_sq_nxt;
                        r_dat    <= w_next;
                    end
                end
                S_CHECK: begin
                    r_pass     <= w_final;
                    r_fail_any <= ~&w_final;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign adc_dat      = r_dat;
    assign adc_valid    = r_valid;
    assign dsp_rst      = r_dsp_rst;
    assign sts_busy     = r_busy;
    assign sts_done     = r_done;
    assign sts_pass     = r_pass;
    assign sts_fail_any = r_fail_any;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_kiwi_bist_ctrl.sv
// Bench for kiwi_bist_ctrl: directed and random self-tests graded cycle by cycle against
// a model that derives run length, samples and pass bits straight from the pattern rules.
module tb_kiwi_bist_ctrl;
    localparam int AW = 16;
    localparam int CH = 3;
    localparam int CW = 16;
    localparam int TW = 32;
    localparam int RC = 16;
    localparam int SQ = 8;

    logic             aclk = 1'b0;
    logic             areset;
    logic [1:0]       cfg_mode;
    logic [AW-1:0]    cfg_step;
    logic [TW-1:0]    cfg_timeout;
    logic [CW-1:0]    cfg_threshold;
    logic             start;
    logic [CH*CW-1:0] fifo_count;
    logic [AW-1:0]    adc_dat;
    logic             adc_valid;
    logic             dsp_rst;
    logic             sts_busy;
    logic             sts_done;
    logic [CH-1:0]    sts_pass;
    logic             sts_fail_any;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int lo[CH];
    int hi[CH];
    int rc[CH];

    always #5 aclk = ~aclk;

    kiwi_bist_ctrl #(
        .ADC_WIDTH(AW), .CHANNELS(CH), .CNT_WIDTH(CW),
        .TIMER_WIDTH(TW), .RST_CYCLES(RC), .SQ_HALF(SQ)
    ) dut (
        .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
        .cfg_timeout(cfg_timeout), .cfg_threshold(cfg_threshold), .start(start),
        .fifo_count(fifo_count), .adc_dat(adc_dat), .adc_valid(adc_valid),
        .dsp_rst(dsp_rst), .sts_busy(sts_busy), .sts_done(sts_done),
        .sts_pass(sts_pass), .sts_fail_any(sts_fail_any), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".adc_dat"}, adc_dat, 0);
        chk({tag, ".adc_valid"}, adc_valid, 0);
        chk({tag, ".dsp_rst"}, dsp_rst, 0);
        chk({tag, ".busy"}, sts_busy, 0);
        chk({tag, ".done"}, sts_done, 0);
        chk({tag, ".pass"}, sts_pass, 0);
        chk({tag, ".fail_any"}, sts_fail_any, 0);
    endtask

    task automatic set_counts(input int l, input int h, input int r);
        for (int i = 0; i < CH; i++) begin
            lo[i] = l; hi[i] = h; rc[i] = r;
        end
    endtask

    // Count seen by channel i during RUN cycle j (negative j: before RUN).
    function automatic logic [CH*CW-1:0] counts_at(input int j);
        logic [CH*CW-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'((j >= rc[i]) ? hi[i] : lo[i]);
        return v;
    endfunction

    task automatic run_test(input logic [1:0] mode, input logic [AW-1:0] step,
                            input logic [TW-1:0] to, input logic [CW-1:0] thr,
                            input bit do_abort, input bit mid_start);
        int            t_eff, run_len, latest, ha, j;
        bit            all_hit, valid;
        logic [CH-1:0] exp_pass;
        logic [31:0]   m_lfsr, prod;
        logic [AW-1:0] exp_dat;

        // Run length: first cycle by which every channel has reached threshold, capped by timeout.
        t_eff   = (to == 0) ? 1 : int'(to);
        latest  = 0;
        all_hit = 1'b1;
        exp_pass = '0;
        run_len = t_eff;
        for (int i = 0; i < CH; i++) begin
            if (lo[i] >= int'(thr)) ha = 0;
            else if (hi[i] >= int'(thr)) ha = rc[i];
            else ha = -1;
            if (ha < 0) all_hit = 1'b0;
            else if (ha > latest) latest = ha;
        end
        if (all_hit && latest + 1 < run_len) run_len = latest + 1;
        for (int i = 0; i < CH; i++) begin
            if (lo[i] >= int'(thr)) exp_pass[i] = 1'b1;
            else if (hi[i] >= int'(thr) && rc[i] <= run_len) exp_pass[i] = 1'b1;
        end

        @(negedge aclk);
        cfg_mode = mode; cfg_step = step; cfg_timeout = to; cfg_threshold = thr;
        start = 1'b1;
        fifo_count = counts_at(-1);
        @(negedge aclk);
        start = 1'b0;
        m_lfsr = 32'h1;
        for (int n = 1; n <= RC + run_len + 3; n++) begin
            j = n - RC - 1;
            if (j == 0) m_lfsr = 32'h1;
            else if (j > 0) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'hA300_0000 : 32'h0);
            prod = 32'(j) * 32'(step);
            case (mode)
                2'd0: exp_dat = prod[AW-1:0];
                2'd1: exp_dat = m_lfsr[AW-1:0];
                2'd2: exp_dat = step;
                default: exp_dat = (((j / SQ) % 2) == 0) ? step : '0;
            endcase
            valid = (j >= 0) && (j < run_len);
            chk("adc_valid", adc_valid, valid);
            chk("adc_dat", adc_dat, valid ? exp_dat : '0);
            chk("dsp_rst", dsp_rst, n <= RC);
            chk("sts_busy", sts_busy, n <= RC + run_len + 1);
            chk("sts_done", sts_done, n >= RC + run_len + 2);
            if (n >= RC + run_len + 2) begin
                chk("sts_pass", sts_pass, exp_pass);
                chk("sts_fail_any", sts_fail_any, ~&exp_pass);
            end else begin
                chk("sts_pass_cleared", sts_pass, 0);
            end
            if (do_abort && j == 20) begin
                areset = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                chk_all_zero("abort");
                @(negedge aclk);
                chk_all_zero("abort_idle");
                return;
            end
            fifo_count    = counts_at(j);
            cfg_mode      = 2'($urandom_range(0, 3));
            cfg_step      = AW'($urandom);
            cfg_timeout   = TW'($urandom_range(0, 5));
            cfg_threshold = CW'($urandom_range(0, 3));
            start         = mid_start && (j == 20);
            @(negedge aclk);
        end
        start = 1'b0;
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; cfg_mode = '0; cfg_step = '0;
        cfg_timeout = '0; cfg_threshold = '0; fifo_count = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_all_zero("reset");
        start = 1'b1;
        @(negedge aclk);
        chk_all_zero("reset_overrides_start");
        areset = 1'b0; start = 1'b0;
        @(negedge aclk);
        chk_all_zero("idle");

        set_counts(0, 5, 10);
        run_test(2'd0, 16'd64, 32'd1000, 16'd1, 1'b0, 1'b0);
        set_counts(0, 0, 0);
        run_test(2'd0, 16'd64, 32'd2000, 16'd1, 1'b0, 1'b0);
        set_counts(100, 100, 0);
        lo[2] = 0; hi[2] = 0;
        run_test(2'd1, 16'd7, 32'd100, 16'd50, 1'b0, 1'b0);
        set_counts(0, 0, 0);
        run_test(2'd3, 16'h1000, 32'd60, 16'd5, 1'b0, 1'b1);
        run_test(2'd0, AW'($urandom), 32'd100, 16'd1, 1'b1, 1'b0);
        set_counts(3, 3, 0);
        run_test(2'd2, AW'($urandom), 32'd0, 16'd0, 1'b0, 1'b0);
        set_counts(2, 9, 4);
        rc[1] = 30;
        run_test(2'd2, 16'hBEEF, 32'd50, 16'd8, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < CH; i++) begin
                lo[i] = $urandom_range(0, 25);
                hi[i] = $urandom_range(0, 25);
                rc[i] = $urandom_range(0, 60);
            end
            run_test(2'($urandom_range(0, 3)), AW'($urandom), TW'($urandom_range(0, 80)),
                     CW'($urandom_range(0, 20)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
